// File: rtl/conv_pkg.sv
// Shared types and constants for the output collector: the frame state encoding,
// the coordinate width and the frame-size helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } collector_state_t;

  localparam int COORD_WIDTH = 32;

  // Outputs per frame, wrapping modulo 2^32 like the hardware counter it is compared against.
  function automatic logic [31:0] frame_total(input int unsigned w, input int unsigned h,
                                              input int unsigned c);
    logic [31:0] t;
    t = w * h;
    t = t * c;
    return t;
  endfunction

endpackage

// File: rtl/output_collector_if.sv
// Pixel capture and stream-out signals of the output collector.
// The slave modport is the collector's view; the master modport is the controller/sink view.
interface output_collector_if #(
  parameter int DATA_WIDTH = 32
);
  import conv_pkg::*;

  logic                   start;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [COORD_WIDTH-1:0] in_x;
  logic [COORD_WIDTH-1:0] in_y;
  logic [COORD_WIDTH-1:0] in_ch;
  logic                   almost_full;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COORD_WIDTH-1:0] out_x;
  logic [COORD_WIDTH-1:0] out_y;
  logic [COORD_WIDTH-1:0] out_ch;
  logic                   running;
  logic                   frame_done;
  logic                   overflow;

  modport master (
    output start, in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  almost_full, out_valid, out_data, out_x, out_y, out_ch,
           running, frame_done, overflow
  );

  modport slave (
    input  start, in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output almost_full, out_valid, out_data, out_x, out_y, out_ch,
           running, frame_done, overflow
  );

endinterface

// File: rtl/output_collector_sync_fifo.sv
// Show-ahead register FIFO; pointers carry one extra wrap bit so full and empty differ.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only and is never reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/output_collector.sv
// Collects finished output pixels from the conv controller, buffers them and streams them out,
// tracking frame progress, backpressure and overflow errors.
module output_collector
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int AF_MARGIN          = 2
) (
  input logic               clk,
  input logic               arst_in,
  output_collector_if.slave bus
);
  localparam logic [31:0] TOTAL =
    frame_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
  localparam int WIDTH = DATA_WIDTH + 3 * COORD_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  collector_state_t state;
  collector_state_t state_next;
  logic [31:0]      push_cnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             ovf_evt;
  logic             last_push;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    free_next;
  logic [WIDTH-1:0] head;
  logic             almost_full;
  logic             overflow;
  logic             running;
  logic             frame_done;

  assign pop       = !empty && bus.out_ready;
  assign push      = bus.in_valid && (state == ACTIVE) && (!full || pop);
  // Any pixel that is not accepted is lost, whatever the reason.
  assign ovf_evt   = bus.in_valid && !push;
  assign last_push = push && (push_cnt + 32'd1 == TOTAL);

  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign free_next  = CW'(FIFO_DEPTH) - count_next;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst_in (arst_in),
    .push    (push),
    .pop     (pop),
    .wdata   ({bus.in_ch, bus.in_y, bus.in_x, bus.in_data}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    running    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_next = ACTIVE;
      ACTIVE: begin
        running = 1'b1;
        if (last_push) state_next = DRAIN;
      end
      DRAIN: begin
        running = 1'b1;
        if (count_next == '0) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A drop in the same cycle as start still flags, so the error is never lost.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      push_cnt    <= '0;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      almost_full <= (free_next <= CW'(AF_MARGIN));
      if (state == IDLE && bus.start) push_cnt <= '0;
      else if (push)                  push_cnt <= push_cnt + 32'd1;
      if (ovf_evt)                         overflow <= 1'b1;
      else if (state == IDLE && bus.start) overflow <= 1'b0;
    end
  end

  assign {bus.out_ch, bus.out_y, bus.out_x, bus.out_data} = head;
  assign bus.out_valid   = !empty;
  assign bus.almost_full = almost_full;
  assign bus.overflow    = overflow;
  assign bus.running     = running;
  assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_output_collector.sv
// Randomized scoreboard bench for output_collector on a 2x2x2 frame with a 4-deep FIFO.
module tb_output_collector;
  localparam int DW    = 32;
  localparam int W     = 2;
  localparam int H     = 2;
  localparam int OC    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 1;
  localparam int TOTAL = W * H * OC;

  typedef struct {
    logic [31:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } entry_t;

  logic clk = 1'b0;
  logic arst_in;
  always #5 clk = ~clk;

  output_collector_if #(.DATA_WIDTH(DW)) bus();

  output_collector #(
    .DATA_WIDTH         (DW),
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H),
    .OUTPUT_NB_CHANNELS (OC),
    .FIFO_DEPTH         (DEPTH),
    .AF_MARGIN          (AF)
  ) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus)
  );

  // Reference model: queue of pixels in flight, frame phase (0 idle, 1 collecting,
  // 2 draining, 3 done pulse), pixels accepted this frame and the sticky error.
  entry_t exp_q[$];
  int     mocc   = 0;
  int     mphase = 0;
  int     macc   = 0;
  bit     movf   = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (!arst_in && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pop_data", bus.out_data, e.d);
        chk("pop_x", bus.out_x, e.x);
        chk("pop_y", bus.out_y, e.y);
        chk("pop_ch", bus.out_ch, e.ch);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_running"}, bus.running, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_almost_full"}, bus.almost_full, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_xyc"}, {bus.out_x | bus.out_y | bus.out_ch}, 0);
  endtask

  // One clock: check the state the DUT shows, drive the next inputs, advance the model.
  task automatic cycle(input bit st, input bit iv, input bit rdy);
    entry_t e;
    bit pop, acc, ovf;
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, mocc != 0);
    if (mocc != 0 && exp_q.size() > 0) begin
      chk("head_data", bus.out_data, exp_q[0].d);
      chk("head_ch", bus.out_ch, exp_q[0].ch);
    end
    chk("almost_full", bus.almost_full, (DEPTH - mocc) <= AF);
    chk("running", bus.running, mphase == 1 || mphase == 2);
    chk("frame_done", bus.frame_done, mphase == 3);
    chk("overflow", bus.overflow, movf);
    e.d  = $urandom;
    e.x  = $urandom;
    e.y  = $urandom;
    e.ch = $urandom;
    bus.start     = st;
    bus.in_valid  = iv;
    bus.in_data   = e.d;
    bus.in_x      = e.x;
    bus.in_y      = e.y;
    bus.in_ch     = e.ch;
    bus.out_ready = rdy;
    pop = (mocc > 0) && rdy;
    acc = iv && (mphase == 1) && (mocc < DEPTH || pop);
    ovf = iv && !acc;
    if (acc) begin
      exp_q.push_back(e);
      macc++;
    end
    mocc = mocc + int'(acc) - int'(pop);
    case (mphase)
      0: if (st) begin mphase = 1; macc = 0; movf = 1'b0; end
      1: if (acc && macc == TOTAL) mphase = 2;
      2: if (mocc == 0) mphase = 3;
      default: mphase = 0;
    endcase
    if (ovf) movf = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cycles, input bit rnd);
    int n;
    n = 0;
    while (mphase != 0 && n < max_cycles) begin
      if (rnd) cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      else     cycle(0, 0, 1);
      n++;
    end
    chk("frame_timeout", mphase != 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 arst_in = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("inrst");
    @(negedge clk);
    #2 arst_in = 1'b0;
    exp_q.delete();
    mocc   = 0;
    mphase = 0;
    macc   = 0;
    movf   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.in_x = '0; bus.in_y = '0; bus.in_ch = '0;
    arst_in = 1'b0;
    #1 arst_in = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_in = 1'b0;

    // Straight-through frame with the sink always ready.
    cycle(1, 0, 1);
    repeat (TOTAL) cycle(0, 1, 1);
    run_until_idle(20, 0);
    repeat (2) cycle(0, 0, 1);

    // Pixel while idle flags overflow; start clears it.
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);

    // Fill to almost-full then full, push while full and popping, then drop while full.
    repeat (DEPTH) cycle(0, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    run_until_idle(300, 1);

    // Reset mid-frame with two pixels buffered, then a fresh frame.
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    async_reset();
    repeat (2) cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_until_idle(300, 1);

    // Whole frame accepted under backpressure, finishing in drain.
    cycle(1, 0, 0);
    repeat (DEPTH) cycle(0, 1, 0);
    repeat (DEPTH) cycle(0, 0, 1);
    repeat (DEPTH) cycle(0, 1, 0);
    repeat (2) cycle(0, 0, 0);
    run_until_idle(20, 0);

    // Random frames.
    repeat (4) begin
      cycle(1, 0, $urandom_range(0, 1) == 1);
      run_until_idle(300, 1);
      cycle(0, 0, 1);
    end

    repeat (3) cycle(0, 0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
